// File: rtl/pht_bimodal_predictor_if.sv
// Lookup and update bus of the bimodal branch predictor.
// The master side is fetch/execute and the slave side is the predictor.
interface pht_bimodal_predictor_if #(
   parameter int INDEX_W = 6
);
   logic               init_busy;
   logic               pred_valid;
   logic [INDEX_W-1:0] pred_idx;
   logic               pred_ready;
   logic               pred_resp_valid;
   logic               pred_taken;
   logic [1:0]         pred_counter;
   logic               upd_valid;
   logic [INDEX_W-1:0] upd_idx;
   logic               upd_taken;
   logic               upd_ready;

   modport master (
      input  init_busy, pred_ready, pred_resp_valid, pred_taken, pred_counter, upd_ready,
      output pred_valid, pred_idx, upd_valid, upd_idx, upd_taken
   );

   modport slave (
      output init_busy, pred_ready, pred_resp_valid, pred_taken, pred_counter, upd_ready,
      input  pred_valid, pred_idx, upd_valid, upd_idx, upd_taken
   );
endinterface

// File: rtl/pht_bimodal_predictor.sv
// Bimodal pattern history table of 2-bit saturating counters.
// It self-initialises after reset, then serves 1-cycle lookups and two-stage updates.
module pht_bimodal_predictor #(
   parameter int         INDEX_W  = 6,
   parameter logic [1:0] INIT_VAL = 2'b01
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pht_bimodal_predictor_if.slave bus
);
   localparam int DEPTH = 1 << INDEX_W;

   typedef enum logic {INIT, RUN} stateT;

   stateT              state;
   stateT              nextState;
   logic [INDEX_W-1:0] initPtr;
   logic [1:0]         counterTable [DEPTH];

   logic               pendValid;
   logic [INDEX_W-1:0] pendIdx;
   logic               pendTaken;
   logic [1:0]         pendCur;
   logic [1:0]         pendNext;
   logic [1:0]         lookupVal;
   logic               predAccept;
   logic               updAccept;
   logic               respValid;
   logic [1:0]         respCounter;
   logic               running;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= INIT;
         initPtr <= '0;
      end else begin
         state <= nextState;
         if (state == INIT)
            initPtr <= initPtr + 1'b1;
      end
   end

   always_comb begin
      nextState = state;
      if (state == INIT && initPtr == {INDEX_W{1'b1}})
         nextState = RUN;
   end

   always_comb begin
      running       = (state == RUN);
      bus.init_busy = !running;
      bus.pred_ready = running;
      bus.upd_ready  = running;
   end

   assign predAccept = bus.pred_valid && running;
   assign updAccept  = bus.upd_valid && running;

   // Saturating 2-bit step applied to the entry owned by the pending update.
   always_comb begin
      pendCur  = counterTable[pendIdx];
      pendNext = pendCur;
      if (pendTaken) begin
         if (pendCur != 2'b11)
            pendNext = pendCur + 2'b01;
      end else begin
         if (pendCur != 2'b00)
            pendNext = pendCur - 2'b01;
      end
   end

   // A lookup must see the write that lands at the end of this same cycle.
   always_comb begin
      lookupVal = counterTable[bus.pred_idx];
      if (pendValid && pendIdx == bus.pred_idx)
         lookupVal = pendNext;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pendValid <= 1'b0;
         pendIdx   <= '0;
         pendTaken <= 1'b0;
      end else begin
         pendValid <= updAccept;
         if (updAccept) begin
            pendIdx   <= bus.upd_idx;
            pendTaken <= bus.upd_taken;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == INIT)
            counterTable[initPtr] <= INIT_VAL;
         else if (pendValid)
            counterTable[pendIdx] <= pendNext;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         respValid   <= 1'b0;
         respCounter <= 2'b00;
      end else begin
         respValid <= predAccept;
         if (predAccept)
            respCounter <= lookupVal;
      end
   end

   assign bus.pred_resp_valid = respValid;
   assign bus.pred_counter    = respCounter;
   assign bus.pred_taken      = respCounter[1];
endmodule

// File: doc/pht_bimodal_predictor.md
Name: pht_bimodal_predictor

Overview:
Bimodal pattern history table of 2-bit saturating counters. It serves branch-direction lookups from fetch and absorbs resolved-branch updates from execute. Internally it applies the standard 2-bit saturating next-value rule. On reset it runs a self-initialisation sweep over every entry before accepting traffic.

Parameters:
INDEX_W, 6, table index width; table depth = 2**INDEX_W entries.
INIT_VAL, 2'b01, counter value written to every entry during the init sweep (weakly not-taken).

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
init_busy  output  1  high while the init sweep runs
pred_valid  input  1  lookup request
pred_idx  input  INDEX_W  lookup table index
pred_ready  output  1  lookup can be accepted (low during init)
pred_resp_valid  output  1  one-cycle pulse, lookup result valid
pred_taken  output  1  predicted direction = counter[1]
pred_counter  output  2  raw counter value of looked-up entry
upd_valid  input  1  update request
upd_idx  input  INDEX_W  entry to update
upd_taken  input  1  resolved direction: 1 = taken, 0 = not taken
upd_ready  output  1  update can be accepted (low during init)

Behaviour:
- Reset (rst_n low at a rising edge):
  - Enter state INIT with init pointer = 0.
  - init_busy=1; pred_ready, upd_ready, pred_resp_valid = 0; pred_taken=0; pred_counter=2'b00.
  - Discard any pending update.
  - The same action applies if reset arrives mid-sweep or mid-operation.
- State INIT:
  - Each cycle, write INIT_VAL to entry[ptr] and increment ptr.
  - The cycle that writes the last entry (ptr = 2**INDEX_W-1) transitions to RUN.
  - Total: exactly 2**INDEX_W cycles after reset deasserts.
  - pred_valid and upd_valid are ignored in INIT.
- State RUN:
  - init_busy=0, pred_ready=1, upd_ready=1.
  - No other states; RUN exits only on reset.
- Update path (two stages):
  - Accept: upd_valid & upd_ready captures upd_idx and upd_taken into a pending register.
  - Next cycle: read entry[pending idx], compute the next value, write it back at the end of that cycle.
  - One update is accepted per cycle, back-to-back, with no stalls. Same-index back-to-back updates each see the prior result: the second update's read happens after the first write lands.
- Next-value rule:
  - Taken: 00→01, 01→10, 10→11, 11→11 (saturate).
  - Not taken: 11→10, 10→01, 01→00, 00→00 (saturate).
- Lookup path, latency 1:
  - Accept: pred_valid & pred_ready in cycle k.
  - Cycle k+1: pred_resp_valid=1, pred_counter = entry value, pred_taken = pred_counter[1].
- Lookup ordering and forwarding:
  - The result reflects every update accepted in cycles before k.
  - If the pending update in cycle k targets pred_idx, forward the computed next value, not the stale table value.
  - An update accepted in the same cycle k as the lookup is NOT reflected.
- Output holding:
  - pred_resp_valid is low in any cycle without a lookup accepted the previous cycle.
  - pred_taken and pred_counter hold their last value when pred_resp_valid is low.
- Width rules: counters are exactly 2 bits; pred_idx and upd_idx are used in full, with no out-of-range condition.

Test Plan:
- Init: INDEX_W=6. Release rst_n → init_busy high for exactly 64 cycles, ready signals low. Then look up idx 0, 37, 63 → pred_counter=01, pred_taken=0 each, response one cycle after accept.
- Saturate up: updates taken ×3 to idx 5 on consecutive cycles, then look up idx 5 → 11, taken=1. A 4th taken update → still 11.
- Saturate down: from 11 at idx 5, not-taken ×4 → 00. A 5th not-taken → 00. Lookup → pred_taken=0.
- Forwarding:
  - Update idx 9 taken accepted in cycle k, lookup idx 9 in cycle k+1 → 10.
  - Lookup idx 9 in cycle k, same cycle as the update → 01.
  - Lookup idx 10 in cycle k+1 → 01 (unaffected).
- Interleave: simultaneous lookup idx 2 and update idx 3 every cycle for 8 cycles. Each response=01 and idx 3 reaches 11. No pred_resp_valid in idle cycles; outputs hold.
- Reset mid-operation: after driving idx 3 to 11, assert rst_n low in the same cycle as an update to idx 3. Then init_busy for 64 cycles, lookup idx 3 → 01, and no response pulse leaks across reset.
